// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: state enum, table entry
// layout and the index-width helper.
package branch_predictor_pkg;

  localparam int XLEN      = 32;
  localparam int CTR_MAX_W = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Tag and counter are zero-extended to fixed widths so one struct serves
  // every ENTRIES/CTR_W combination.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      tag;
    logic [XLEN-1:0]      target;
    logic [CTR_MAX_W-1:0] ctr;
  } entry_t;

  function automatic int idx_w(input int entries);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < entries) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-update and flush signals of the branch predictor,
// with the FSM state exposed as dbg_state.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [XLEN-1:0] lk_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next_pc;

  // upd_valid is a single-cycle strobe with no ready/backpressure: it is
  // accepted on the rising edge when busy = 0 and flush_req = 0, else dropped.
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  logic            flush_req;
  logic            busy;
  logic [XLEN-1:0] br_count;
  logic [XLEN-1:0] mp_count;
  state_t          dbg_state;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_req,
    input  pred_taken, pred_next_pc, mispredict, redirect_pc,
           busy, br_count, mp_count, dbg_state
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_req,
    output pred_taken, pred_next_pc, mispredict, redirect_pc,
           busy, br_count, mp_count, dbg_state
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter step: clamps at 0 and 2^CTR_W - 1.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_MAX_W-1:0] cur,
  input  logic                 up,
  output logic [CTR_MAX_W-1:0] nxt
);

  localparam logic [CTR_MAX_W-1:0] CTR_MAX = CTR_MAX_W'((1 << CTR_W) - 1);

  always_comb begin
    nxt = cur;
    if (up) begin
      if (cur < CTR_MAX) nxt = cur + CTR_MAX_W'(1);
    end else if (cur != '0) begin
      nxt = cur - CTR_MAX_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, zero-latency lookup, EX-stage update and an invalidation sweep.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);

  localparam int                   IDX_W       = idx_w(ENTRIES);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(ENTRIES - 1);
  localparam logic [CTR_MAX_W-1:0] CTR_WEAK_T  = CTR_MAX_W'(1 << (CTR_W - 1));
  localparam logic [CTR_MAX_W-1:0] CTR_WEAK_NT = CTR_MAX_W'((1 << (CTR_W - 1)) - 1);

  entry_t               table_q [ENTRIES];
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]      br_q, mp_q;

  logic [IDX_W-1:0]     lk_idx, upd_idx;
  entry_t               lk_e, upd_e, upd_new;
  logic                 lk_hit, upd_hit, busy, pred_taken;
  logic                 mispredict, accept, upd_wr;
  logic [CTR_MAX_W-1:0] ctr_nxt;

  assign busy = (state_q == INIT);

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  assign lk_idx     = bp.lk_pc[IDX_W+1:2];
  assign lk_e       = table_q[lk_idx];
  assign lk_hit     = lk_e.valid && (lk_e.tag == (bp.lk_pc >> (IDX_W + 2)));
  assign pred_taken = lk_hit && lk_e.ctr[CTR_W-1] && !busy;

  assign upd_idx = bp.upd_pc[IDX_W+1:2];
  assign upd_e   = table_q[upd_idx];
  assign upd_hit = upd_e.valid && (upd_e.tag == (bp.upd_pc >> (IDX_W + 2)));

  assign mispredict = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
  assign accept     = bp.upd_valid && !busy && !bp.flush_req;

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .cur (upd_e.ctr),
    .up  (bp.upd_taken),
    .nxt (ctr_nxt)
  );

  always_comb begin
    upd_wr  = 1'b0;
    upd_new = upd_e;
    if (accept) begin
      if (upd_hit) begin
        upd_wr      = 1'b1;
        upd_new.ctr = ctr_nxt;
        if (bp.upd_taken) upd_new.target = bp.upd_target;
      end else if (bp.upd_taken) begin
        upd_wr         = 1'b1;
        upd_new.valid  = 1'b1;
        upd_new.tag    = bp.upd_pc >> (IDX_W + 2);
        upd_new.target = bp.upd_target;
        upd_new.ctr    = CTR_WEAK_T;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        if (bp.flush_req) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READY: begin
        if (bp.flush_req) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
    end else if (busy) begin
      table_q[idx_q].valid <= 1'b0;
      table_q[idx_q].ctr   <= CTR_WEAK_NT;
    end else if (upd_wr) begin
      table_q[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (accept) begin
      if (br_q != '1) br_q <= br_q + 1'b1;
      if (mispredict && (mp_q != '1)) mp_q <= mp_q + 1'b1;
    end
  end

  assign bp.pred_taken   = pred_taken;
  assign bp.pred_next_pc = pred_taken ? lk_e.target : bp.lk_pc + 32'd4;
  assign bp.mispredict   = mispredict;
  assign bp.redirect_pc  = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
  assign bp.busy         = busy;
  assign bp.br_count     = br_q;
  assign bp.mp_count     = mp_q;
  assign bp.dbg_state    = state_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor (ENTRIES=16, CTR_W=2)
// against a table-level reference model.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CTR_TOP = (1 << CTR_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  longint      m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_busy_left;
  longint      m_br, m_mp;

  function automatic int m_index(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % ENTRIES);
  endfunction

  function automatic longint m_tagof(input logic [31:0] pc);
    return longint'(pc) / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_busy_left = ENTRIES;
    m_br = 0;
    m_mp = 0;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, sample the combinational outputs,
  // advance the model by one rising edge, then move to the next falling edge.
  task automatic step(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic upt,
                      input logic [31:0] uptgt, input logic fl);
    bit   e_pt, e_mp;
    int   i;
    bp_if.lk_pc           = lk;
    bp_if.upd_valid       = uv;
    bp_if.upd_pc          = upc;
    bp_if.upd_taken       = ut;
    bp_if.upd_target      = utgt;
    bp_if.upd_pred_taken  = upt;
    bp_if.upd_pred_target = uptgt;
    bp_if.flush_req       = fl;
    #1;
    e_pt = (m_busy_left == 0) && m_hit(lk) && (m_ctr[m_index(lk)] >= (1 << (CTR_W - 1)));
    e_mp = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    exp_q.push_back(32'(m_busy_left > 0));             check("busy", 32'(bp_if.busy));
    exp_q.push_back(32'(e_pt));                         check("pred_taken", 32'(bp_if.pred_taken));
    exp_q.push_back(e_pt ? m_target[m_index(lk)] : lk + 32'd4);
    check("pred_next_pc", bp_if.pred_next_pc);
    exp_q.push_back(32'(e_mp));                         check("mispredict", 32'(bp_if.mispredict));
    exp_q.push_back(ut ? utgt : upc + 32'd4);          check("redirect_pc", bp_if.redirect_pc);
    exp_q.push_back(m_br[31:0]);                        check("br_count", bp_if.br_count);
    exp_q.push_back(m_mp[31:0]);                        check("mp_count", bp_if.mp_count);

    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      m_busy_left = ENTRIES;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (uv) begin
      i = m_index(upc);
      if (m_hit(upc)) begin
        m_ctr[i] = ut ? ((m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (ut) m_target[i] = utgt;
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = m_tagof(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 1 << (CTR_W - 1);
      end
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (e_mp && (m_mp < 64'hFFFF_FFFF)) m_mp++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] lk);
    step(lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lk, input logic [31:0] pc, input logic t,
                     input logic [31:0] tgt);
    step(lk, 1'b1, pc, t, tgt, t, t ? tgt : pc + 32'd4, 1'b0);
  endtask

  // Asynchronous reset pulse taken mid-cycle, checked while still asserted.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(32'd1);                 check("rst_busy", 32'(bp_if.busy));
    exp_q.push_back(32'd0);                 check("rst_pred_taken", 32'(bp_if.pred_taken));
    exp_q.push_back(bp_if.lk_pc + 32'd4);   check("rst_pred_next_pc", bp_if.pred_next_pc);
    exp_q.push_back(32'd0);                 check("rst_br_count", bp_if.br_count);
    exp_q.push_back(32'd0);                 check("rst_mp_count", bp_if.mp_count);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] lk, pc, tgt;
    logic        t, pt, uv, fl;
    bp_if.lk_pc = 32'h40;
    bp_if.upd_valid = 1'b0;
    bp_if.upd_pc = '0;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_target = '0;
    bp_if.upd_pred_taken = 1'b0;
    bp_if.upd_pred_target = '0;
    bp_if.flush_req = 1'b0;
    model_reset();
    @(negedge clk);
    reset_pulse();

    // Sweep after reset: 16 busy cycles, lookups at 0x40 predict 0x44.
    for (int n = 0; n < ENTRIES + 2; n++) idle(32'h40);

    // Allocate 0x40 (predicted not-taken -> mispredict), then hit.
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    idle(32'h40);
    // Not-taken x3 (2->1->0->0), then taken x4 (->3), then one not-taken (3->2).
    for (int n = 0; n < 3; n++) upd(32'h40, 32'h40, 1'b0, 32'h100);
    idle(32'h40);
    for (int n = 0; n < 4; n++) upd(32'h40, 32'h40, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'h100);
    idle(32'h40);
    // Alias: same index 0, different tag.
    idle(32'h80);
    // Mispredict on an unseen taken branch.
    step(32'h300, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 32'h304, 1'b0);
    idle(32'h300);
    // Flush with a simultaneous update: update dropped, table emptied.
    step(32'h40, 1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 32'h84, 1'b1);
    for (int n = 0; n < ENTRIES + 1; n++) idle(32'h40);
    idle(32'h300);
    idle(32'h80);

    // Randomized traffic over a few indices and tags to force hits and aliases.
    for (int n = 0; n < 400; n++) begin
      lk  = 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2));
      pc  = 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2));
      tgt = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000;
      t   = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      uv  = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 79) == 0);
      step(lk, uv, pc, t, tgt, pt, pt ? 32'h1000 : pc + 32'd4, fl);
      if (n == 200) reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
